hazard_ctrl: RTL and testbench

- Hazard/stall controller that sequences the IF/ID pipeline register and the PC of the 5-stage core.
- Generates pc_write, if_id_write and if_flush for IF/ID, plus id_ex_bubble for the ID/EX control mux.
- Handles three cases:
  - load-use stalls;
  - branch-taken flushes, including a flush deferred while stalled;
  - multi-cycle multiply/divide (MDU) waits, with a timeout and a saturating stall-cycle counter.

---
 rtl/hazard_ctrl_pkg.sv | 13 +
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/hazard_ctrl_load_use_detect.sv | 17 +
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the IF/ID hazard controller and its helpers.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_e;

    localparam logic [4:0]  REG_ZERO        = 5'd0;
    localparam int unsigned MDU_TIMEOUT_DEF = 64;
    localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller; slave = controller, master = pipeline.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = hazard_pkg::CNT_W_DEF
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             branch_taken;
    logic             mdu_start;
    logic             mdu_done;
    logic             pc_write;
    logic             if_id_write;
    logic             if_flush;
    logic             id_ex_bubble;
    logic             busy;
    logic             mdu_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               branch_taken, mdu_start, mdu_done,
        input  pc_write, if_id_write, if_flush, id_ex_bubble,
               busy, mdu_timeout, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               branch_taken, mdu_start, mdu_done,
        output pc_write, if_id_write, if_flush, id_ex_bubble,
               busy, mdu_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use comparator: a load in EX writes a register the ID instruction reads.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       lu
);

    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign lu = ex_mem_read && (ex_rt != REG_ZERO) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for PC and IF/ID: load-use stalls, branch flushes, MDU waits.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_TIMEOUT = MDU_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    hazard_ctrl_if.slave   hz
);

    localparam int unsigned        WCNT_W   = $clog2(MDU_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0]  WCNT_MAX = WCNT_W'(MDU_TIMEOUT);

    state_e              state_q, state_d;
    logic                pend_flush_q, pend_flush_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                lu;
    logic                pc_write;

    load_use_detect u_lu (
        .id_rs       (hz.id_rs),
        .id_rt       (hz.id_rt),
        .id_uses_rt  (hz.id_uses_rt),
        .ex_mem_read (hz.ex_mem_read),
        .ex_rt       (hz.ex_rt),
        .lu          (lu)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_flush_q <= 1'b0;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            stall_q      <= '0;
        end else begin
            pend_flush_q <= pend_flush_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
            stall_q      <= stall_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_flush_d = pend_flush_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        unique case (state_q)
            RUN: begin
                if (hz.mdu_start) begin
                    state_d    = MDU_WAIT;
                    wait_cnt_d = '0;
                    if (hz.branch_taken) pend_flush_d = 1'b1;
                end
            end
            MDU_WAIT: begin
                if (hz.mdu_done) begin
                    state_d      = RUN;
                    pend_flush_d = 1'b0;
                end else begin
                    if (wait_cnt_q != WCNT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_d == WCNT_MAX) timeout_d = 1'b1;
                    if (hz.branch_taken) pend_flush_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        stall_d = stall_q;
        if (!pc_write && (stall_q != '1)) stall_d = stall_q + 1'b1;
    end

    always_comb begin
        pc_write        = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.if_flush     = 1'b0;
        hz.id_ex_bubble = 1'b0;
        hz.busy         = 1'b0;
        if (reset) begin
            pc_write        = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.if_flush     = 1'b1;
            hz.id_ex_bubble = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    // a load-use stall drops a same-cycle branch; it re-resolves next cycle
                    if (hz.mdu_start || lu) begin
                        pc_write        = 1'b0;
                        hz.if_id_write  = 1'b0;
                        hz.id_ex_bubble = 1'b1;
                    end else if (hz.branch_taken) begin
                        hz.if_flush = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    hz.busy = 1'b1;
                    if (hz.mdu_done) begin
                        hz.if_flush = pend_flush_q | hz.branch_taken;
                    end else begin
                        pc_write        = 1'b0;
                        hz.if_id_write  = 1'b0;
                        hz.id_ex_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.mdu_timeout  = timeout_q;
    assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl plus timeout and counter-saturation sequences.
module tb_hazard_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) ifa ();
    hazard_ctrl_if #(.CNT_W(4))  ifb ();

    hazard_ctrl #(.MDU_TIMEOUT(8), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .hz(ifa));
    hazard_ctrl #(.CNT_W(4))                   dut_b (.clk(clk), .reset(reset), .hz(ifb));

    assign ifb.id_rs        = ifa.id_rs;
    assign ifb.id_rt        = ifa.id_rt;
    assign ifb.id_uses_rt   = ifa.id_uses_rt;
    assign ifb.ex_mem_read  = ifa.ex_mem_read;
    assign ifb.ex_rt        = ifa.ex_rt;
    assign ifb.branch_taken = ifa.branch_taken;
    assign ifb.mdu_start    = ifa.mdu_start;
    assign ifb.mdu_done     = ifa.mdu_done;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       mr;
        logic [4:0] ert;
        logic       br;
        logic       st;
        logic       dn;
        logic [4:0] exp;  // {pc_write, if_id_write, if_flush, id_ex_bubble, busy}
    } vec_t;

    vec_t tbl[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    function automatic vec_t v(logic r, logic [4:0] rs, logic [4:0] rt, logic urt, logic mr,
                               logic [4:0] ert, logic br, logic st, logic dn, logic [4:0] exp);
        vec_t t;
        t.rst = r; t.rs = rs; t.rt = rt; t.urt = urt; t.mr = mr;
        t.ert = ert; t.br = br; t.st = st; t.dn = dn; t.exp = exp;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        reset            = t.rst;
        ifa.id_rs        = t.rs;
        ifa.id_rt        = t.rt;
        ifa.id_uses_rt   = t.urt;
        ifa.ex_mem_read  = t.mr;
        ifa.ex_rt        = t.ert;
        ifa.branch_taken = t.br;
        ifa.mdu_start    = t.st;
        ifa.mdu_done     = t.dn;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [4:0] outs_a();
        return {ifa.pc_write, ifa.if_id_write, ifa.if_flush, ifa.id_ex_bubble, ifa.busy};
    endfunction

    initial begin
        logic        valid;
        int unsigned exp_st;
        valid  = 1'b0;
        exp_st = 0;

        //          rst rs  rt  urt mr ert br st dn   pc ifid fl bub busy
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
        tbl.push_back(v(0, 5, 0, 0, 1, 5, 0, 0, 0, 5'b00010)); // load-use on rs
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b11000)); // load to r0
        tbl.push_back(v(0, 3, 5, 0, 1, 5, 0, 0, 0, 5'b11000)); // rt match, rt unused
        tbl.push_back(v(0, 3, 5, 1, 1, 5, 0, 0, 0, 5'b00010)); // rt match, rt used
        tbl.push_back(v(0, 4, 6, 1, 1, 5, 0, 0, 0, 5'b11000));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11100)); // branch flush
        tbl.push_back(v(0, 5, 0, 0, 1, 5, 1, 0, 0, 5'b00010)); // load-use beats branch
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00010)); // mdu start
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00011));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00011));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00011));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11001)); // release, no flush
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00010));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00011));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00011)); // branch while waiting
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11101)); // deferred flush
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00010));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11001)); // pending flush was cleared
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00010)); // start with branch
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00011)); // start while busy ignored
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11101));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00010));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, 5'b11101)); // branch in done cycle
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00010));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110)); // reset while in MDU_WAIT
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("outs[%0d]", i), 32'(outs_a()), 32'(tbl[i].exp));
            if (valid) begin
                chk($sformatf("stall[%0d]", i), 32'(ifa.stall_cycles), exp_st);
                chk($sformatf("tmo[%0d]", i), 32'(ifa.mdu_timeout), 32'd0);
            end
            tick();
            if (tbl[i].rst) begin
                valid  = 1'b1;
                exp_st = 0;
            end else if (!tbl[i].exp[4]) begin
                exp_st++;
            end
        end

        // timeout and counter saturation
        drive(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
        tick();
        tick();
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
        #1;
        chk("rst_stall_a", 32'(ifa.stall_cycles), 32'd0);
        chk("rst_stall_b", 32'(ifb.stall_cycles), 32'd0);
        tick();
        drive(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b0));
        tick();
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
        for (int w = 1; w <= 20; w++) begin
            #1;
            chk($sformatf("tmo_wait%0d", w), 32'(ifa.mdu_timeout), (w >= 9) ? 32'd1 : 32'd0);
            chk($sformatf("busy_wait%0d", w), 32'(ifa.busy), 32'd1);
            chk($sformatf("stall_wait%0d", w), 32'(ifa.stall_cycles), 32'(w));
            tick();
        end
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b0));
        #1;
        chk("tmo_release", 32'(outs_a()), 32'(5'b11001));
        tick();
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
        #1;
        chk("stall_a_total", 32'(ifa.stall_cycles), 32'd21);
        chk("stall_b_sat", 32'(ifb.stall_cycles), 32'd15);
        chk("tmo_b_none", 32'(ifb.mdu_timeout), 32'd0);
        tick();
        tick();
        tick();
        #1;
        chk("tmo_sticky", 32'(ifa.mdu_timeout), 32'd1);
        chk("stall_b_hold", 32'(ifb.stall_cycles), 32'd15);
        drive(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
        tick();
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
        #1;
        chk("tmo_cleared", 32'(ifa.mdu_timeout), 32'd0);
        chk("stall_cleared", 32'(ifa.stall_cycles), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
